// File: rtl/mcu_pkg.sv
// ----------------------------------------------------------------------------
// mcu_pkg
// Definitions shared between the stage sequencer and the control unit:
//   - 2-bit stage codes that the control unit decodes (LOAD/FETCH/DECODE/EXECUTE)
//   - the sequencer's FSM state type
//   - a helper that maps a sequencer state onto the stage code it drives
// ----------------------------------------------------------------------------
package mcu_pkg;

    localparam logic [1:0] STAGE_LOAD    = 2'b00;
    localparam logic [1:0] STAGE_FETCH   = 2'b01;
    localparam logic [1:0] STAGE_DECODE  = 2'b10;
    localparam logic [1:0] STAGE_EXECUTE = 2'b11;

    typedef enum logic [2:0] {
        S_LOAD   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_HALT   = 3'd4
    } seq_state_e;

    // HALT presents FETCH to the control unit; core_en=0 keeps the datapath
    // frozen, so the control unit sees a stable, harmless stage while parked.
    function automatic logic [1:0] stage_of(input seq_state_e st);
        logic [1:0] code;
        code = STAGE_LOAD;
        case (st)
            S_LOAD:   code = STAGE_LOAD;
            S_FETCH:  code = STAGE_FETCH;
            S_DECODE: code = STAGE_DECODE;
            S_EXEC:   code = STAGE_EXECUTE;
            S_HALT:   code = STAGE_FETCH;
            default:  code = STAGE_LOAD;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/mcu_stage_sequencer.sv
// ----------------------------------------------------------------------------
// mcu_stage_sequencer
// Owns the processor stage register. First streams a program image into
// program memory over a valid/ready port, then runs the FETCH-DECODE-EXECUTE
// cycle, with halt at instruction boundaries, single-step, reload and a
// retired-instruction counter.
//
// Ports
//   clk, rst                  clock; synchronous active-high reset
//   ld_valid/ld_data/ld_last  program image stream in
//   ld_ready                  word accepted this cycle when ld_valid=1
//   pmem_we/addr/wdata        program memory write port (load only)
//   halt_req                  level: park at the next instruction boundary
//   step_req                  pulse: run one instruction while halted
//   reload_req                pulse: go back to LOAD at the next boundary
//   stage                     2-bit stage code to the control unit
//   core_en                   datapath register enables live
//   halted                    parked in HALT
//   load_ovf                  sticky: memory filled without ld_last
//   retired                   count of EXECUTE cycles, wraps
// ----------------------------------------------------------------------------
module mcu_stage_sequencer
    import mcu_pkg::*;
#(
    parameter int PMEM_DEPTH = 256,
    parameter int ADDR_W     = 8,
    parameter int INSTR_W    = 12,
    parameter int CNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ld_valid,
    input  logic [INSTR_W-1:0] ld_data,
    input  logic               ld_last,
    output logic               ld_ready,
    output logic               pmem_we,
    output logic [ADDR_W-1:0]  pmem_addr,
    output logic [INSTR_W-1:0] pmem_wdata,
    input  logic               halt_req,
    input  logic               step_req,
    input  logic               reload_req,
    output logic [1:0]         stage,
    output logic               core_en,
    output logic               halted,
    output logic               load_ovf,
    output logic [CNT_W-1:0]   retired
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PMEM_DEPTH - 1);

    seq_state_e         state_q, state_d;
    logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic               load_ovf_q, load_ovf_d;
    logic [CNT_W-1:0]   retired_q, retired_d;
    logic               reload_pend_q, reload_pend_d;
    logic               step_mode_q, step_mode_d;

    logic               accept;
    logic               reload_now;

    // Load port: ready only in LOAD and never while reset is asserted, so a
    // word presented during reset is not written.
    assign ld_ready   = (state_q == S_LOAD) & ~rst;
    assign accept     = ld_valid & ld_ready;
    assign pmem_we    = accept;
    assign pmem_addr  = wr_ptr_q;
    assign pmem_wdata = ld_data;

    // A reload request arriving in the EXECUTE cycle itself is honoured at
    // that same boundary rather than one instruction later.
    assign reload_now = reload_pend_q | reload_req;

    assign stage    = stage_of(state_q);
    assign core_en  = (state_q == S_FETCH) | (state_q == S_DECODE) | (state_q == S_EXEC);
    assign halted   = (state_q == S_HALT);
    assign load_ovf = load_ovf_q;
    assign retired  = retired_q;

    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        load_ovf_d    = load_ovf_q;
        retired_d     = retired_q;
        reload_pend_d = reload_pend_q;
        step_mode_d   = step_mode_q;

        case (state_q)
            S_LOAD: begin
                if (accept) begin
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    if (ld_last) begin
                        state_d = S_FETCH;
                    end else if (wr_ptr_q == LAST_ADDR) begin
                        // Memory full with no end marker: run what we have
                        // and flag the truncated image.
                        state_d    = S_FETCH;
                        load_ovf_d = 1'b1;
                    end
                end
            end

            S_FETCH: begin
                if (reload_req) reload_pend_d = 1'b1;
                state_d = S_DECODE;
            end

            S_DECODE: begin
                if (reload_req) reload_pend_d = 1'b1;
                state_d = S_EXEC;
            end

            S_EXEC: begin
                retired_d = retired_q + 1'b1;
                if (reload_now) begin
                    state_d       = S_LOAD;
                    wr_ptr_d      = '0;
                    load_ovf_d    = 1'b0;
                    reload_pend_d = 1'b0;
                    step_mode_d   = 1'b0;
                end else if (halt_req | step_mode_q) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_FETCH;
                end
            end

            S_HALT: begin
                if (reload_now) begin
                    state_d       = S_LOAD;
                    wr_ptr_d      = '0;
                    load_ovf_d    = 1'b0;
                    reload_pend_d = 1'b0;
                    step_mode_d   = 1'b0;
                end else if (step_req) begin
                    // step_mode sends EXECUTE straight back to HALT even if
                    // halt_req has been dropped in the meantime.
                    state_d     = S_FETCH;
                    step_mode_d = 1'b1;
                end else if (!halt_req) begin
                    state_d     = S_FETCH;
                    step_mode_d = 1'b0;
                end
            end

            default: begin
                state_d = S_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_LOAD;
            wr_ptr_q      <= '0;
            load_ovf_q    <= 1'b0;
            retired_q     <= '0;
            reload_pend_q <= 1'b0;
            step_mode_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            load_ovf_q    <= load_ovf_d;
            retired_q     <= retired_d;
            reload_pend_q <= reload_pend_d;
            step_mode_q   <= step_mode_d;
        end
    end

endmodule
